exe_stage_mc: RTL and testbench

- Parametrised, multi-cycle execute stage for the ARM pipeline.
- Single-cycle ALU ops, plus an iterative MUL/MLA unit processing K multiplier bits per cycle.
- Internal NZCV status register; carry-in comes from that register.
- Outputs are registered, so the block also serves as the EXE/MEM boundary. It asserts `busy` to stall upstream stages while a multiply is in flight.

---
 rtl/exe_stage_mc.sv | 204 ++++++++++++++++++++
 tb/tb_exe_stage_mc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mc.sv
// Execute stage with single-cycle ALU, iterative K-bit-per-cycle MUL/MLA,
// internal NZCV status and registered outputs forming the EXE/MEM boundary.
module exe_stage_mc #(
    parameter int unsigned W        = 32,
    parameter int unsigned K        = 2,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [3:0]   exe_cmd,
    input  logic         s_update,
    input  logic         mem_r_en,
    input  logic         mem_w_en,
    input  logic         wb_en,
    input  logic [3:0]   dest,
    input  logic [W-1:0] pc,
    input  logic [W-1:0] val_rn,
    input  logic [W-1:0] val2,
    input  logic [W-1:0] val_ra,
    input  logic [23:0]  signed_imm_24,
    output logic         busy,
    output logic         out_valid,
    output logic [W-1:0] alu_result,
    output logic [W-1:0] br_addr,
    output logic         mem_r_en_out,
    output logic         mem_w_en_out,
    output logic         wb_en_out,
    output logic [3:0]   dest_out,
    output logic [3:0]   status
);
    localparam int unsigned N  = W / K;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;
    typedef enum logic [3:0] {
        OP_MOV = 4'b0001, OP_ADD = 4'b0010, OP_ADC = 4'b0011, OP_SUB = 4'b0100,
        OP_SBC = 4'b0101, OP_AND = 4'b0110, OP_ORR = 4'b0111, OP_EOR = 4'b1000,
        OP_MVN = 4'b1001, OP_MUL = 4'b1010, OP_MLA = 4'b1011
    } op_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mul_s_q, mul_s_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   alu_result_q, alu_result_d;
    logic [W-1:0]   br_addr_q, br_addr_d;
    logic           mem_r_en_q, mem_r_en_d;
    logic           mem_w_en_q, mem_w_en_d;
    logic           wb_en_q, wb_en_d;
    logic [3:0]     dest_q, dest_d;
    logic [3:0]     status_q, status_d;

    logic           mem_op, s_eff, cin, arith, known, is_mul, mla, ovf;
    logic [3:0]     op;
    logic [W-1:0]   b_eff, alu_res, br_off, part, acc_next;
    logic [W:0]     sum;

    // Single-cycle ALU: subtraction is rn + ~val2 + cin so carry-out is "no borrow"
    always_comb begin
        mem_op  = mem_r_en | mem_w_en;
        op      = mem_op ? OP_ADD : exe_cmd;
        s_eff   = s_update & ~mem_op;
        b_eff   = val2;
        cin     = 1'b0;
        arith   = 1'b0;
        known   = 1'b1;
        is_mul  = 1'b0;
        mla     = 1'b0;
        alu_res = '0;
        case (op)
            OP_MOV: alu_res = val2;
            OP_MVN: alu_res = ~val2;
            OP_ADD: arith = 1'b1;
            OP_ADC: begin arith = 1'b1; cin = status_q[1]; end
            OP_SUB: begin arith = 1'b1; b_eff = ~val2; cin = 1'b1; end
            OP_SBC: begin arith = 1'b1; b_eff = ~val2; cin = status_q[1]; end
            OP_AND: alu_res = val_rn & val2;
            OP_ORR: alu_res = val_rn | val2;
            OP_EOR: alu_res = val_rn ^ val2;
            OP_MUL: is_mul = 1'b1;
            OP_MLA: begin is_mul = 1'b1; mla = 1'b1; end
            default: known = 1'b0;
        endcase
        sum = {1'b0, val_rn} + {1'b0, b_eff} + {{W{1'b0}}, cin};
        if (arith) alu_res = sum[W-1:0];
        ovf = (val_rn[W-1] == b_eff[W-1]) && (sum[W-1] != val_rn[W-1]);
        br_off = W'({{W{signed_imm_24[23]}}, signed_imm_24} << BR_SHIFT);
        // Multiplicand is pre-shifted each step so the partial product lands in place
        part     = mcand_q * W'(mplier_q[K-1:0]);
        acc_next = acc_q + part;
    end

    // Next-state: accept in IDLE, iterate in MUL; flush kills work and out_valid
    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mul_s_d      = mul_s_q;
        out_valid_d  = 1'b0;
        alu_result_d = alu_result_q;
        br_addr_d    = br_addr_q;
        mem_r_en_d   = mem_r_en_q;
        mem_w_en_d   = mem_w_en_q;
        wb_en_d      = wb_en_q;
        dest_d       = dest_q;
        status_d     = status_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    br_addr_d  = pc + br_off;
                    mem_r_en_d = mem_r_en;
                    mem_w_en_d = mem_w_en;
                    wb_en_d    = wb_en;
                    dest_d     = dest;
                    if (is_mul) begin
                        state_d  = ST_MUL;
                        mcand_d  = val_rn;
                        mplier_d = val2;
                        acc_d    = mla ? val_ra : '0;
                        cnt_d    = CW'(N - 1);
                        mul_s_d  = s_eff;
                    end else begin
                        alu_result_d = alu_res;
                        out_valid_d  = 1'b1;
                        if (s_eff && known)
                            status_d = {alu_res[W-1], alu_res == '0,
                                        arith ? sum[W] : status_q[1],
                                        arith ? ovf : status_q[0]};
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << K;
                    mplier_d = mplier_q >> K;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d      = ST_IDLE;
                        alu_result_d = acc_next;
                        out_valid_d  = 1'b1;
                        if (mul_s_q)
                            status_d = {acc_next[W-1], acc_next == '0, status_q[1:0]};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            mul_s_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            br_addr_q    <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            dest_q       <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mul_s_q      <= mul_s_d;
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            br_addr_q    <= br_addr_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            wb_en_q      <= wb_en_d;
            dest_q       <= dest_d;
            status_q     <= status_d;
        end
    end

    assign busy         = (state_q == ST_MUL);
    assign out_valid    = out_valid_q;
    assign alu_result   = alu_result_q;
    assign br_addr      = br_addr_q;
    assign mem_r_en_out = mem_r_en_q;
    assign mem_w_en_out = mem_w_en_q;
    assign wb_en_out    = wb_en_q;
    assign dest_out     = dest_q;
    assign status       = status_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Randomized self-checking bench for exe_stage_mc (W=32, K=2, BR_SHIFT=2)
// against an arithmetic reference model of the execute stage.
module tb_exe_stage_mc;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk, rst, flush, in_valid, s_update, mem_r_en, mem_w_en, wb_en;
    logic [3:0]  exe_cmd, dest;
    logic [31:0] pc, val_rn, val2, val_ra;
    logic [23:0] signed_imm_24;
    logic        busy, out_valid, mem_r_en_out, mem_w_en_out, wb_en_out;
    logic [31:0] alu_result, br_addr;
    logic [3:0]  dest_out, status;

    int checks = 0;
    int failures = 0;
    logic [3:0] model_status;

    exe_stage_mc #(.W(32), .K(2), .BR_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .exe_cmd(exe_cmd), .s_update(s_update), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en(wb_en), .dest(dest), .pc(pc),
        .val_rn(val_rn), .val2(val2), .val_ra(val_ra),
        .signed_imm_24(signed_imm_24), .busy(busy), .out_valid(out_valid),
        .alu_result(alu_result), .br_addr(br_addr),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .dest_out(dest_out), .status(status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic, flags from signed range checks
    function automatic void ref_exec(input logic [3:0] cmd, input logic [31:0] a, b, ra,
                                     input logic s, mem, input logic [3:0] st,
                                     output logic [31:0] res, output logic [3:0] nst);
        longint unsigned ua, ub, t, bw;
        longint sa;
        logic c, v, known;
        logic [3:0] op;
        op = mem ? 4'd2 : cmd;
        ua = {32'd0, a};
        ub = {32'd0, b};
        c = st[1];
        v = st[0];
        known = 1'b1;
        res = 32'd0;
        case (op)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                bw = (op == 4'd3) ? {63'd0, st[1]} : 64'd0;
                t = ua + ub + bw;
                res = t[31:0];
                c = t[32];
                sa = longint'($signed(a)) + longint'($signed(b)) + longint'(bw);
                v = (sa > SMAX) || (sa < SMIN);
            end
            4'd4, 4'd5: begin
                bw = (op == 4'd5) ? {63'd0, !st[1]} : 64'd0;
                t = ua - ub - bw;
                res = t[31:0];
                c = (ua >= ub + bw);
                sa = longint'($signed(a)) - longint'($signed(b)) - longint'(bw);
                v = (sa > SMAX) || (sa < SMIN);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            4'd10: begin t = ua * ub; res = t[31:0]; end
            4'd11: begin t = ua * ub + {32'd0, ra}; res = t[31:0]; end
            default: known = 1'b0;
        endcase
        nst = st;
        if (s && !mem && known) nst = {res[31], res == 32'd0, c, v};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_garbage();
        exe_cmd = 4'($urandom); val_rn = $urandom; val2 = $urandom; val_ra = $urandom;
        dest = 4'($urandom); wb_en = 1'($urandom); s_update = 1'b1; pc = $urandom;
        signed_imm_24 = 24'($urandom); mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, b, ra, input logic s,
                         input logic mr, mw, input logic [31:0] pcv, input logic [23:0] imm);
        logic [31:0] eres, ebr;
        logic [3:0]  est, edst;
        logic        ewb, is_mul;
        int          cyc;
        ref_exec(cmd, a, b, ra, s, mr | mw, model_status, eres, est);
        ebr = pcv + 32'(int'($signed(imm)) * 4);
        edst = 4'($urandom);
        ewb = 1'($urandom);
        is_mul = !mr && !mw && (cmd == 4'd10 || cmd == 4'd11);
        @(negedge clk);
        exe_cmd = cmd; val_rn = a; val2 = b; val_ra = ra; s_update = s;
        mem_r_en = mr; mem_w_en = mw; wb_en = ewb; dest = edst; pc = pcv;
        signed_imm_24 = imm; flush = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("br_addr", br_addr, ebr);
        check_eq("mem_r_out", {31'd0, mem_r_en_out}, {31'd0, mr});
        check_eq("mem_w_out", {31'd0, mem_w_en_out}, {31'd0, mw});
        if (!is_mul) begin
            check_eq("alu_valid", {31'd0, out_valid}, 32'd1);
            check_eq("alu_result", alu_result, eres);
            check_eq("alu_status", {28'd0, status}, {28'd0, est});
        end else begin
            check_eq("mul_busy", {31'd0, busy}, 32'd1);
            cyc = 0;
            while (!out_valid && cyc < 40) begin
                @(negedge clk);
                drive_garbage();
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                cyc++;
            end
            check_eq("mul_latency", cyc, 32'd16);
            check_eq("mul_result", alu_result, eres);
            check_eq("mul_status", {28'd0, status}, {28'd0, est});
            check_eq("mul_busy_end", {31'd0, busy}, 32'd0);
        end
        check_eq("dest_out", {28'd0, dest_out}, {28'd0, edst});
        check_eq("wb_out", {31'd0, wb_en_out}, {31'd0, ewb});
        model_status = est;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ov_seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        drive_garbage();
        model_status = 4'd0;
        @(posedge clk); #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_result", alu_result, 32'd0);
        check_eq("rst_br", br_addr, 32'd0);
        check_eq("rst_status", {28'd0, status}, 32'd0);
        check_eq("rst_dest", {28'd0, dest_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        issue(4'd2, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0, 24'h0);
        check_eq("add_12", alu_result, 32'd12);
        idle_cycle();
        issue(4'd4, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0, 24'h0);
        check_eq("cmp_status", {28'd0, status}, 32'h6);
        issue(4'd3, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0);
        check_eq("adc_3", alu_result, 32'd3);
        issue(4'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0, 24'h0);
        check_eq("ovf_status", {28'd0, status}, 32'h9);
        issue(4'd6, 32'hF0, 32'h0F, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0, 24'h0);
        check_eq("and_keep_cv", {28'd0, status}, 32'h5);
        issue(4'd11, 32'hFFFF, 32'h1_0001, 32'd1, 1'b1, 1'b0, 1'b0, 32'h0, 24'h0);
        check_eq("mla_zero", alu_result, 32'd0);
        check_eq("mla_status", {28'd0, status}, 32'h5);
        issue(4'd4, 32'd9, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1, 32'h100, 24'hFFFFFE);
        check_eq("br_neg", br_addr, 32'h0F8);
        check_eq("str_sum", alu_result, 32'd10);
        check_eq("str_status", {28'd0, status}, 32'h5);

        // Flush mid-multiply
        @(negedge clk);
        exe_cmd = 4'd10; val_rn = 32'd1234; val2 = 32'd5678; s_update = 1'b1;
        mem_r_en = 1'b0; mem_w_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("fl_busy_on", {31'd0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("fl_busy_off", {31'd0, busy}, 32'd0);
        check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
        check_eq("fl_status", {28'd0, status}, {28'd0, model_status});
        ov_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check_eq("fl_no_done", ov_seen, 32'd0);
        // Flush together with in_valid must not accept
        @(negedge clk);
        exe_cmd = 4'd2; val_rn = 32'd1; val2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("fl_no_accept", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-multiply
        issue(4'd1, 32'd0, 32'h0000_ABCD, 32'd0, 1'b1, 1'b0, 1'b0, 32'h40, 24'h1);
        issue(4'd10, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0, 24'h0);
        @(negedge clk);
        exe_cmd = 4'd10; val_rn = 32'd77; val2 = 32'd99; pc = 32'h1234; dest = 4'hA;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_result", alu_result, 32'd0);
        check_eq("arst_br", br_addr, 32'd0);
        check_eq("arst_status", {28'd0, status}, 32'd0);
        check_eq("arst_dest", {28'd0, dest_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_status = 4'd0;

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [3:0] cmd;
            int unsigned r;
            cmd = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 7);
            issue(cmd, pick(), pick(), pick(), 1'($urandom), r == 0, r == 1,
                  $urandom, 24'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
